sha256_compress: RTL

- Downstream consumer of the padding stage's 32-bit word stream.
- Collects one 512-bit block as 16 big-endian words (one per valid cycle), then runs the 64-round SHA-256 compression at one round per clock.
- Adds the result into the running hash state and presents the 256-bit digest with a one-cycle valid pulse.
- Supports multi-block chaining so longer messages can be hashed block by block.

---
 rtl/sha256_pkg.sv | 66 ++++++
 rtl/sha256_round.sv | 32 +++
 rtl/sha256_compress.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants, state encoding and bit-level helper functions
// for the SHA-256 compression block.
//   K      : 64 round constants
//   IV     : initial hash value H0..H7
//   state_t: LOAD (collect 16 words), ROUND (one round per clock), FINAL (add into H)
//   big_sigma0/1, small_sigma0/1, ch, maj: the SHA-256 logical functions
package sha256_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Rotations are written as fixed concatenations so no shifter is inferred.
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b00_0000_0000, x[31:10]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 round.
//   work      : current working variables, work[0]=a ... work[7]=h
//   k         : round constant K[t]
//   w         : message schedule word W[t]
//   next_work : working variables after the round, same ordering
module sha256_round
  import sha256_pkg::*;
(
  input  logic [7:0][31:0] work,
  input  logic [31:0]      k,
  input  logic [31:0]      w,
  output logic [7:0][31:0] next_work
);

  logic [31:0] t1_s;
  logic [31:0] t2_s;

  // Round function; every sum wraps at 32 bits.
  always_comb begin
    t1_s = work[7] + big_sigma1(work[4]) + ch(work[4], work[5], work[6]) + k + w;
    t2_s = big_sigma0(work[0]) + maj(work[0], work[1], work[2]);
    next_work[0] = t1_s + t2_s;
    next_work[1] = work[0];
    next_work[2] = work[1];
    next_work[3] = work[2];
    next_work[4] = work[3] + t1_s;
    next_work[5] = work[4];
    next_work[6] = work[5];
    next_work[7] = work[6];
  end

endmodule

// File: rtl/sha256_compress.sv
// sha256_compress: collects a 512-bit block as 16 big-endian words, runs the
// SHA-256 compression at one round per clock and accumulates into H.
//   clk, rst        : clock, synchronous active-high reset
//   valid_i, M_i    : message word stream, word 0 first
//   chain_i         : with word 0 only; 1 = continue from current H, 0 = from IV
//   busy_o          : word-0 capture until the digest pulse
//   digest_valid_o  : one-cycle pulse when digest_o updates
//   digest_o        : {H0..H7}, H0 in [255:224]
//   overrun_o       : sticky, a word arrived while computing
module sha256_compress
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [31:0]  M_i,
  input  logic         chain_i,
  output logic         busy_o,
  output logic         digest_valid_o,
  output logic [255:0] digest_o,
  output logic         overrun_o
);

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

  state_t           state_r;
  logic [3:0]       wcnt_r;
  logic [5:0]       rcnt_r;
  // During ROUND the window always holds W[t..t+15], so W[t] is slot 0.
  logic [31:0]      w_r [0:15];
  logic [31:0]      h_r [0:7];
  logic [7:0][31:0] work_r;
  logic [7:0][31:0] next_work_s;
  logic [31:0]      w_new_s;
  logic [31:0]      h_sum_s [0:7];
  logic [255:0]     digest_s;

  sha256_round u_round (
    .work      (work_r),
    .k         (K[rcnt_r]),
    .w         (w_r[0]),
    .next_work (next_work_s)
  );

  // Schedule word W[t+16] from the window, plus the feed-forward sums for FINAL.
  always_comb begin
    w_new_s  = small_sigma1(w_r[14]) + w_r[9] + small_sigma0(w_r[1]) + w_r[0];
    digest_s = '0;
    for (int i = 0; i < 8; i++) begin
      h_sum_s[i]                = h_r[i] + work_r[i];
      digest_s[32*(7-i) +: 32] = h_sum_s[i];
    end
  end

  // Control FSM, counters, W window, working and hash registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= LOAD;
      wcnt_r         <= 4'd0;
      rcnt_r         <= 6'd0;
      work_r         <= '0;
      busy_o         <= 1'b0;
      digest_valid_o <= 1'b0;
      digest_o       <= 256'd0;
      overrun_o      <= 1'b0;
      for (int i = 0; i < 16; i++) w_r[i] <= 32'd0;
      for (int i = 0; i < 8; i++)  h_r[i] <= IV[i];
    end else begin
      digest_valid_o <= 1'b0;
      case (state_r)
        LOAD: begin
          if (valid_i) begin
            w_r[wcnt_r] <= M_i;
            wcnt_r      <= wcnt_r + 4'd1;
            if (wcnt_r == 4'd0) begin
              busy_o <= 1'b1;
              // Starting fresh: H itself restarts from IV so FINAL adds onto IV.
              if (!chain_i) begin
                for (int i = 0; i < 8; i++) h_r[i] <= IV[i];
              end
            end
            if (wcnt_r == 4'd15) begin
              wcnt_r  <= 4'd0;
              rcnt_r  <= 6'd0;
              state_r <= ROUND;
              for (int i = 0; i < 8; i++) work_r[i] <= h_r[i];
            end
          end
        end
        ROUND: begin
          work_r <= next_work_s;
          for (int i = 0; i < 15; i++) w_r[i] <= w_r[i+1];
          w_r[15] <= w_new_s;
          rcnt_r  <= rcnt_r + 6'd1;
          if (rcnt_r == LAST_ROUND) begin
            state_r <= FINAL;
          end
          if (valid_i) begin
            overrun_o <= 1'b1;
          end
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) h_r[i] <= h_sum_s[i];
          digest_o       <= digest_s;
          digest_valid_o <= 1'b1;
          busy_o         <= 1'b0;
          state_r        <= LOAD;
          if (valid_i) begin
            overrun_o <= 1'b1;
          end
        end
        default: begin
          state_r <= LOAD;
        end
      endcase
    end
  end

endmodule
